instruction_fetch: RTL and testbench

Fetch stage of the MIPS pipeline, directly downstream of `pc`: consumes the registered program counter and produces the fetched instruction and PC+4 for the IF/ID latch. It owns the instruction memory, a load port the debug unit uses to write the program before execution, and halt detection that freezes fetch when the halt word is reached. Stall and flush inputs come from the hazard unit.

---
 rtl/instruction_fetch_pkg.sv | 14 +
 rtl/instruction_fetch_instr_mem.sv | 29 ++
 rtl/instruction_fetch.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared constants and state encoding for the MIPS fetch stage.
package instruction_fetch_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_instr_mem.sv
// Single-port instruction RAM with synchronous read. There is deliberately no
// reset and no read-data initialisation so the array maps onto block RAM and
// the loaded program survives a pipeline reset.
module instr_mem #(
    parameter int len    = 32,
    parameter int depth  = 1024,
    parameter int addr_w = $clog2(depth)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [addr_w-1:0] addr,
    input  logic [len-1:0]    wr_data,
    output logic [len-1:0]    rd_data
);

    logic [len-1:0] mem [depth];

    // One shared address port: writes during program load, gated reads during run.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the instruction memory, the debug load port and halt
// detection. The RAM read register doubles as the instruction output register;
// a separate "fetched" flag decides whether that word or a NOP is presented.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int len   = 32,
    parameter int depth = 1024
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [len-1:0] i_pc,
    input  logic           i_stall,
    input  logic           i_flush,
    input  logic           i_run,
    input  logic           i_wr_valid,
    input  logic [len-1:0] i_wr_data,
    output logic           o_wr_ready,
    output logic [len-1:0] o_instr,
    output logic [len-1:0] o_pc_plus4,
    output logic           o_valid,
    output logic           o_halt
);

    localparam int              addr_w     = $clog2(depth);
    localparam logic [addr_w:0] wptr_limit = (addr_w + 1)'(depth);
    localparam logic [addr_w:0] wptr_one   = (addr_w + 1)'(1);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [addr_w:0]   wptr;
    logic [addr_w:0]   wptr_next;
    logic              wr_ready;
    logic              wr_ready_next;
    logic              fetched;
    logic              fetched_next;
    logic              halt_reg;
    logic              halt_next;
    logic [len-1:0]    pc_plus4;
    logic [len-1:0]    pc_plus4_next;
    logic              mem_we;
    logic              mem_re;
    logic [addr_w-1:0] mem_addr;
    logic [len-1:0]    mem_rdata;
    logic              halt_seen;
    logic              unused_pc_bits;

    // Byte-offset bits and bits above the memory size play no part in addressing.
    assign unused_pc_bits = ^{i_pc[len-1:addr_w+2], i_pc[1:0]};

    // The halt word is recognised as it comes out of the RAM, so o_halt rises in
    // the very cycle that word would otherwise have been shown on o_instr.
    assign halt_seen = (state == RUN) && fetched && (mem_rdata == len'(HALT_WORD));

    instr_mem #(
        .len    (len),
        .depth  (depth),
        .addr_w (addr_w)
    ) u_instr_mem (
        .clk     (i_clk),
        .wr_en   (mem_we),
        .rd_en   (mem_re),
        .addr    (mem_addr),
        .wr_data (i_wr_data),
        .rd_data (mem_rdata)
    );

    // Next-state, load-pointer and fetch-register decisions; flush beats stall beats fetch.
    always_comb begin
        state_next    = state;
        wptr_next     = wptr;
        fetched_next  = fetched;
        halt_next     = halt_reg;
        pc_plus4_next = pc_plus4;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        mem_addr      = i_pc[addr_w+1:2];

        case (state)
            LOAD: begin
                mem_addr     = wptr[addr_w-1:0];
                fetched_next = 1'b0;
                halt_next    = 1'b0;
                if (i_wr_valid && wr_ready) begin
                    mem_we    = 1'b1;
                    wptr_next = wptr + wptr_one;
                end
                if (i_run) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (halt_seen) begin
                    fetched_next = 1'b0;
                    halt_next    = 1'b1;
                    state_next   = HALTED;
                end else if (i_flush) begin
                    fetched_next = 1'b0;
                end else if (!i_stall) begin
                    mem_re        = 1'b1;
                    fetched_next  = 1'b1;
                    pc_plus4_next = i_pc + len'(PC_INC);
                end
            end
            HALTED: begin
                fetched_next = 1'b0;
                halt_next    = 1'b1;
            end
            default: begin
                state_next = LOAD;
            end
        endcase

        wr_ready_next = (state_next == LOAD) && (wptr_next < wptr_limit);
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Load pointer, registered load-port ready and fetch output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr     <= '0;
            wr_ready <= 1'b1;
            fetched  <= 1'b0;
            halt_reg <= 1'b0;
            pc_plus4 <= '0;
        end else begin
            wptr     <= wptr_next;
            wr_ready <= wr_ready_next;
            fetched  <= fetched_next;
            halt_reg <= halt_next;
            pc_plus4 <= pc_plus4_next;
        end
    end

    assign o_wr_ready = wr_ready;
    assign o_pc_plus4 = pc_plus4;
    assign o_valid    = fetched && !halt_seen;
    assign o_instr    = o_valid ? mem_rdata : len'(NOP_WORD);
    assign o_halt     = halt_reg || halt_seen;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for the fetch stage: vector table for the run-time behaviour
// plus hand-written sequences for reset, load overflow and address wrap.
module tb_instruction_fetch;

    localparam int LEN   = 32;
    localparam int DEPTH = 1024;

    localparam logic [31:0] W0 = 32'h2001_0005;
    localparam logic [31:0] W1 = 32'h2002_0003;
    localparam logic [31:0] W2 = 32'h0022_1820;
    localparam logic [31:0] W3 = 32'hFFFF_FFFF;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic        run;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        logic        exp_valid;
        logic        exp_halt;
        logic        exp_ready;
    } vec_t;

    logic            clk;
    logic            rst;
    logic [LEN-1:0]  pc;
    logic            stall;
    logic            flush;
    logic            run;
    logic            wr_valid;
    logic [LEN-1:0]  wr_data;
    logic            wr_ready;
    logic [LEN-1:0]  instr;
    logic [LEN-1:0]  pc_plus4;
    logic            valid;
    logic            halt;

    int passed;
    int total;
    int accepted;

    vec_t vecs[12];
    logic [31:0] prog[4];

    instruction_fetch #(
        .len   (LEN),
        .depth (DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_pc       (pc),
        .i_stall    (stall),
        .i_flush    (flush),
        .i_run      (run),
        .i_wr_valid (wr_valid),
        .i_wr_data  (wr_data),
        .o_wr_ready (wr_ready),
        .o_instr    (instr),
        .o_pc_plus4 (pc_plus4),
        .o_valid    (valid),
        .o_halt     (halt)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] p, input logic s, input logic f, input logic r);
        pc    = p;
        stall = s;
        flush = f;
        run   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        pc       = '0;
        stall    = 1'b0;
        flush    = 1'b0;
        run      = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        passed   = 0;
        total    = 0;
        accepted = 0;

        prog[0] = W0;
        prog[1] = W1;
        prog[2] = W2;
        prog[3] = W3;

        vecs[0]  = '{"fetch0",       32'h0000_0000, 1'b0, 1'b0, 1'b0, W0,    32'h0000_0004, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{"stall1",       32'h0000_0004, 1'b1, 1'b0, 1'b0, W0,    32'h0000_0004, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{"stall2",       32'h0000_0004, 1'b1, 1'b0, 1'b0, W0,    32'h0000_0004, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"resume1",      32'h0000_0004, 1'b0, 1'b0, 1'b0, W1,    32'h0000_0008, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{"flush_stall",  32'h0000_0008, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"fetch2",       32'h0000_0008, 1'b0, 1'b0, 1'b0, W2,    32'h0000_000C, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{"wrap_1004",    32'h0000_1004, 1'b0, 1'b0, 1'b0, W1,    32'h0000_1008, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{"flush_halt",   32'h0000_000C, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_1008, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{"halt_fetch",   32'h0000_000C, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0010, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{"halted_run",   32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0010, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{"halted_flush", 32'h0000_0004, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0000_0010, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{"halted_fetch", 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0010, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset_instr", instr, 32'h0);
        checkOutput("reset_pc4",   pc_plus4, 32'h0);
        checkOutput("reset_valid", {31'b0, valid}, 32'h0);
        checkOutput("reset_halt",  {31'b0, halt}, 32'h0);
        checkOutput("reset_ready", {31'b0, wr_ready}, 32'h1);

        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = prog[i];
            @(posedge clk);
            #1;
            checkOutput("load_ready", {31'b0, wr_ready}, 32'h1);
        end
        wr_valid = 1'b0;

        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("enter_run_valid", {31'b0, valid}, 32'h0);
        checkOutput("enter_run_ready", {31'b0, wr_ready}, 32'h0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].pc, vecs[i].stall, vecs[i].flush, vecs[i].run);
            checkOutput({vecs[i].name, "_instr"}, instr, vecs[i].exp_instr);
            checkOutput({vecs[i].name, "_pc4"},   pc_plus4, vecs[i].exp_pc4);
            checkOutput({vecs[i].name, "_valid"}, {31'b0, valid}, {31'b0, vecs[i].exp_valid});
            checkOutput({vecs[i].name, "_halt"},  {31'b0, halt}, {31'b0, vecs[i].exp_halt});
            checkOutput({vecs[i].name, "_ready"}, {31'b0, wr_ready}, {31'b0, vecs[i].exp_ready});
        end

        // Reset in the middle of running: outputs clear without waiting for a clock edge.
        pulseReset();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h4, 1'b0, 1'b0, 1'b0);
        checkOutput("prereset_instr", instr, W1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_instr", instr, 32'h0);
        checkOutput("async_rst_pc4",   pc_plus4, 32'h0);
        checkOutput("async_rst_valid", {31'b0, valid}, 32'h0);
        checkOutput("async_rst_ready", {31'b0, wr_ready}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("refetch_instr", instr, W0);
        checkOutput("refetch_pc4",   pc_plus4, 32'h4);
        checkOutput("refetch_valid", {31'b0, valid}, 32'h1);

        // Overfill the load port: only DEPTH words land, nothing wraps onto word 0.
        pulseReset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hA000_0000 + 32'(i);
            if (wr_ready) begin
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        checkOutput("accepted_words", 32'(accepted), 32'(DEPTH));
        checkOutput("full_ready",     {31'b0, wr_ready}, 32'h0);

        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        checkOutput("word0_kept", instr, 32'hA000_0000);
        applyStimulus(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        checkOutput("top_word_instr", instr, 32'hA000_03FF);
        checkOutput("pc4_wrap",       pc_plus4, 32'h0);
        applyStimulus(32'h0000_1004, 1'b0, 1'b0, 1'b0);
        checkOutput("alias_1004_instr", instr, 32'hA000_0001);
        checkOutput("alias_1004_pc4",   pc_plus4, 32'h0000_1008);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
